hub75_scan_driver: RTL and testbench

- Parametrised HUB75 LED panel scan engine, the next generation of the panel output path behind the board-level tops.
- Reads pixels from a frame-buffer read port and shifts them out on CHAINS parallel RGB lanes.
- Drives the row address, latch, output-enable and shift clock.
- Applies binary-coded-modulation (BCM) colour depth: each plane is shifted while the previous plane is displayed.

---
 rtl/hub75_scan_driver.sv | 136 +++++++++++++
 tb/tb_hub75_scan_driver.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/hub75_scan_driver.sv
// HUB75 scan engine: shifts BCM colour planes out of a frame buffer while the previous plane is displayed.
// Optional macro HUB75_BRIGHTNESS_EN adds a global brightness input that shortens the oe-low window.
module hub75_scan_driver #(
  parameter int WIDTH       = 64,
  parameter int ADDR_BITS   = 3,
  parameter int DEPTH       = 4,
  parameter int CHAINS      = 1,
  parameter int BASE_CYCLES = 32
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 en,
`ifdef HUB75_BRIGHTNESS_EN
  input  logic [7:0]                           brightness,
`endif
  output logic                                 fb_rd_en,
  output logic [ADDR_BITS+$clog2(WIDTH)-1:0]   fb_addr,
  input  logic [6*CHAINS*DEPTH-1:0]            fb_data,
  output logic [6*CHAINS-1:0]                  rgb,
  output logic [ADDR_BITS-1:0]                 a,
  output logic                                 oe,
  output logic                                 lat,
  output logic                                 oclk,
  output logic                                 frame_sync
);

  localparam int COL_W   = $clog2(WIDTH);
  localparam int STEP_W  = COL_W + 2;
  localparam int TW      = $clog2(BASE_CYCLES << (DEPTH - 1)) + 1;
  localparam int PLANE_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [2:0] {IDLE, SHIFT, WAIT, BLANK, LATCH} state_t;

  state_t               state, next_state;
  logic [ADDR_BITS-1:0] row;
  logic [PLANE_W-1:0]   plane;
  logic [STEP_W-1:0]    step;
  logic [TW-1:0]        timer;
  logic [TW-1:0]        period;
  logic [6*CHAINS-1:0]  rgb_q;
  logic [6*CHAINS-1:0]  plane_bits;
  logic [ADDR_BITS-1:0] a_q;
  logic                 last_step;

  // Pick the current plane's bit out of each colour's DEPTH-bit group.
  for (genvar c = 0; c < CHAINS; c++) begin : g_chain
    for (genvar k = 0; k < 6; k++) begin : g_colour
      logic [DEPTH-1:0] planes;
      assign planes                = fb_data[(c*6+k)*DEPTH +: DEPTH];
      assign plane_bits[c*6+k]     = planes[plane];
    end
  end

  assign last_step = (step == STEP_W'(2 * WIDTH));
  assign period    = TW'(BASE_CYCLES) << plane;

  always_comb begin
    next_state = state;
    fb_rd_en   = 1'b0;
    fb_addr    = '0;
    oclk       = 1'b0;
    lat        = 1'b0;
    frame_sync = 1'b0;
    a          = a_q;
    rgb        = rgb_q;
    case (state)
      IDLE: if (en) next_state = SHIFT;
      SHIFT: begin
        // Even steps issue the read for the next pixel; odd steps present it with oclk low.
        if (!step[0] && !last_step) begin
          fb_rd_en = 1'b1;
          fb_addr  = {row, step[COL_W:1]};
        end
        if (step[0]) rgb = plane_bits;
        else if (step != '0) oclk = 1'b1;
        if (last_step) next_state = WAIT;
      end
      WAIT:  if (timer == '0) next_state = BLANK;
      BLANK: next_state = LATCH;
      LATCH: begin
        lat        = 1'b1;
        a          = row;
        frame_sync = (row == '0) && (plane == '0);
        next_state = en ? SHIFT : IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      row   <= '0;
      plane <= '0;
      step  <= '0;
      timer <= '0;
      rgb_q <= '0;
      a_q   <= '0;
    end else begin
      state <= next_state;
      step  <= (state == SHIFT && !last_step) ? step + 1'b1 : '0;
      if (state == SHIFT && step[0]) rgb_q <= plane_bits;
      if (state == LATCH) begin
        timer <= period;
        a_q   <= row;
        if (plane == PLANE_W'(DEPTH - 1)) begin
          plane <= '0;
          row   <= row + 1'b1;
        end else begin
          plane <= plane + 1'b1;
        end
      end else if (timer != '0) begin
        timer <= timer - 1'b1;
      end
    end
  end

`ifdef HUB75_BRIGHTNESS_EN
  logic [TW-1:0]   on_timer;
  logic [TW+7:0]   on_product;

  assign on_product = (TW+8)'(period) * (TW+8)'(brightness);

  // A second counter covers only the lit fraction; the main timer still paces the scan.
  always_ff @(posedge clk) begin
    if (rst)                 on_timer <= '0;
    else if (state == LATCH) on_timer <= TW'(on_product >> 8);
    else if (on_timer != '0) on_timer <= on_timer - 1'b1;
  end

  assign oe = (on_timer == '0);
`else
  assign oe = (timer == '0);
`endif

endmodule

// File: tb/tb_hub75_scan_driver.sv
// Directed bench for hub75_scan_driver with WIDTH=4, ADDR_BITS=1, DEPTH=2, BASE_CYCLES=16.
// Build with HUB75_BRIGHTNESS_EN to exercise the brightness window as well.
module tb_hub75_scan_driver;

  localparam int WIDTH       = 4;
  localparam int ADDR_BITS   = 1;
  localparam int DEPTH       = 2;
  localparam int CHAINS      = 1;
  localparam int BASE_CYCLES = 16;
`ifdef HUB75_BRIGHTNESS_EN
  localparam int LOW0 = 8;
  localparam int LOW1 = 16;
`else
  localparam int LOW0 = 16;
  localparam int LOW1 = 32;
`endif

  logic        clk;
  logic        rst;
  logic        en;
  logic        fb_rd_en;
  logic [2:0]  fb_addr;
  logic [11:0] fb_data;
  logic [5:0]  rgb;
  logic [0:0]  a;
  logic        oe;
  logic        lat;
  logic        oclk;
  logic        frame_sync;
`ifdef HUB75_BRIGHTNESS_EN
  logic [7:0]  brightness;
`endif

  int checks = 0;
  int errors = 0;

  hub75_scan_driver #(
    .WIDTH(WIDTH), .ADDR_BITS(ADDR_BITS), .DEPTH(DEPTH),
    .CHAINS(CHAINS), .BASE_CYCLES(BASE_CYCLES)
  ) dut (
    .clk(clk),
    .rst(rst),
    .en(en),
`ifdef HUB75_BRIGHTNESS_EN
    .brightness(brightness),
`endif
    .fb_rd_en(fb_rd_en),
    .fb_addr(fb_addr),
    .fb_data(fb_data),
    .rgb(rgb),
    .a(a),
    .oe(oe),
    .lat(lat),
    .oclk(oclk),
    .frame_sync(frame_sync)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Row 0 is 0b01 per colour except column 3 (mixed); row 1 is 0b10 per colour.
  function automatic logic [11:0] pixWord(input logic [2:0] adr);
    if (adr[2])              return 12'hAAA;
    else if (adr[1:0] == 2'd3) return 12'h999;
    else                     return 12'h555;
  endfunction

  // Synchronous-read frame buffer: data valid the cycle after the strobe, zero otherwise.
  always @(posedge clk) fb_data <= fb_rd_en ? pixWord(fb_addr) : 12'h000;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Runs until the next latch; measures the plane shifted and the display of the previous one.
  task automatic applyStimulus(input logic [0:0] expRow, input int startRead,
                               output int lowCnt, output int clkCnt, output int readCnt,
                               output int badAddr, output int firstRead, output int latCyc,
                               output int stray, output int unstable, output logic [23:0] px,
                               output logic [0:0] latA, output logic latFs);
    logic [5:0] prevRgb;
    lowCnt = 0; clkCnt = 0; readCnt = startRead; badAddr = 0; firstRead = 0;
    latCyc = 0; stray = 0; unstable = 0; px = '0; latA = 'x; latFs = 1'bx;
    prevRgb = rgb;
    for (int cyc = 1; cyc <= 200; cyc++) begin
      tick();
      if (oe === 1'b0) lowCnt++;
      if (fb_rd_en === 1'b1) begin
        if (firstRead == 0) firstRead = cyc;
        if (fb_addr !== {expRow, readCnt[1:0]}) badAddr++;
        readCnt++;
      end
      if (oclk === 1'b1) begin
        if (rgb !== prevRgb) unstable++;
        if (clkCnt < 4) px[clkCnt*6 +: 6] = rgb;
        clkCnt++;
      end
      if (frame_sync === 1'b1 && lat !== 1'b1) stray++;
      prevRgb = rgb;
      if (lat === 1'b1) begin
        latCyc = cyc;
        latA   = a;
        latFs  = frame_sync;
        break;
      end
    end
  endtask

  // expLat of 0 means the plane follows a dark period, where only a short window is fixed.
  task automatic checkPlane(input string tag, input logic [0:0] expRow, input int startRead,
                            input int expFirst, input int expLow, input int expLat,
                            input logic [23:0] expPx, input logic expFs);
    int lowCnt, clkCnt, readCnt, badAddr, firstRead, latCyc, stray, unstable;
    logic [23:0] px;
    logic [0:0]  latA;
    logic        latFs;
    applyStimulus(expRow, startRead, lowCnt, clkCnt, readCnt, badAddr, firstRead,
                  latCyc, stray, unstable, px, latA, latFs);
    checkOutput({tag, " first read"}, 32'(firstRead), 32'(expFirst));
    checkOutput({tag, " reads"}, 32'(readCnt), 32'(WIDTH));
    checkOutput({tag, " read addr"}, 32'(badAddr), 32'd0);
    checkOutput({tag, " oclk edges"}, 32'(clkCnt), 32'(WIDTH));
    checkOutput({tag, " rgb stable"}, 32'(unstable), 32'd0);
    checkOutput({tag, " pixels"}, 32'(px), 32'(expPx));
    checkOutput({tag, " oe low"}, 32'(lowCnt), 32'(expLow));
    if (expLat > 0) checkOutput({tag, " lat cycle"}, 32'(latCyc), 32'(expLat));
    else            checkOutput({tag, " lat window"}, 32'(latCyc >= 11 && latCyc <= 12), 32'd1);
    checkOutput({tag, " lat a"}, 32'(latA), 32'(expRow));
    checkOutput({tag, " frame_sync"}, 32'(latFs), 32'(expFs));
    checkOutput({tag, " stray sync"}, 32'(stray), 32'd0);
  endtask

  initial begin
    int lows, reads, lats, clks;
    rst = 1'b1;
    en  = 1'b1;
`ifdef HUB75_BRIGHTNESS_EN
    brightness = 8'd128;
`endif
    repeat (3) tick();
    checkOutput("reset rgb", 32'(rgb), 32'd0);
    checkOutput("reset a", 32'(a), 32'd0);
    checkOutput("reset oe", 32'(oe), 32'd1);
    checkOutput("reset lat", 32'(lat), 32'd0);
    checkOutput("reset oclk", 32'(oclk), 32'd0);
    checkOutput("reset rd_en", 32'(fb_rd_en), 32'd0);
    checkOutput("reset addr", 32'(fb_addr), 32'd0);
    checkOutput("reset sync", 32'(frame_sync), 32'd0);

    rst = 1'b0;
    checkPlane("r0p0", 1'b0, 0, 1, 0, 0, 24'h57FFFF, 1'b1);
    checkPlane("r0p1", 1'b0, 0, 1, LOW0, 19, 24'hA80000, 1'b0);
    checkPlane("r1p0", 1'b1, 0, 1, LOW1, 35, 24'h000000, 1'b0);
    checkPlane("r1p1", 1'b1, 0, 1, LOW0, 19, 24'hFFFFFF, 1'b0);
    checkPlane("wrap", 1'b0, 0, 1, LOW1, 35, 24'h57FFFF, 1'b1);

    // Drop en one cycle into the shift of row 0 plane 1.
    tick();
    checkOutput("drop rd_en", 32'(fb_rd_en), 32'd1);
    checkOutput("drop oe", 32'(oe), 32'd0);
    en = 1'b0;
    checkPlane("drop", 1'b0, 1, 2, LOW0 - 1, 18, 24'hA80000, 1'b0);
    lows = 0; reads = 0; lats = 0; clks = 0;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (oe === 1'b0) lows++;
      if (fb_rd_en === 1'b1) reads++;
      if (lat === 1'b1) lats++;
      if (oclk === 1'b1) clks++;
    end
    checkOutput("idle oe low", 32'(lows), 32'(LOW1));
    checkOutput("idle reads", 32'(reads), 32'd0);
    checkOutput("idle lats", 32'(lats), 32'd0);
    checkOutput("idle oclk", 32'(clks), 32'd0);
    checkOutput("idle oe end", 32'(oe), 32'd1);

    en = 1'b1;
    checkPlane("resume", 1'b1, 0, 1, 0, 0, 24'h000000, 1'b0);

    // Reset in the middle of row 1's display.
    tick();
    tick();
    checkOutput("pre-rst oe", 32'(oe), 32'd0);
    rst = 1'b1;
    tick();
    checkOutput("rst oe", 32'(oe), 32'd1);
    checkOutput("rst lat", 32'(lat), 32'd0);
    checkOutput("rst oclk", 32'(oclk), 32'd0);
    checkOutput("rst a", 32'(a), 32'd0);
    checkOutput("rst rd_en", 32'(fb_rd_en), 32'd0);
    checkOutput("rst rgb", 32'(rgb), 32'd0);
    rst = 1'b0;
    checkPlane("restart", 1'b0, 0, 1, 0, 0, 24'h57FFFF, 1'b1);
    checkPlane("restart p1", 1'b0, 0, 1, LOW0, 19, 24'hA80000, 1'b0);

`ifdef HUB75_BRIGHTNESS_EN
    brightness = 8'd0;
    checkPlane("dim r1p0", 1'b1, 0, 1, LOW1, 35, 24'h000000, 1'b0);
    checkPlane("dark r1p1", 1'b1, 0, 1, 0, 19, 24'hFFFFFF, 1'b0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
